mptw_mem_arbiter: RTL

Arbitrates the MEM-protocol master ports of the three MPT walkers (load, store, IF) onto one shared MEM port that feeds a single MEM-to-D$ converter, freeing two data-cache ports when `SMMPT` is set. Sits between the walker instances and the converter inside the MPU data interface. It holds the winning request stable until granted, tracks up to `MaxOutstanding` in-flight reads in an ID FIFO, and routes in-order responses back to the issuing walker.

---
 rtl/mptw_mem_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/mptw_mem_arbiter.sv
// mptw_mem_arbiter: merges three MPT walker MEM ports onto one shared port with an in-order response ID FIFO.
// Define MPTW_ARB_RR_EN for round-robin arbitration; fixed priority (0 > 1 > 2) otherwise.
module mptw_mem_arbiter #(
    parameter int unsigned NumReq         = 3,
    parameter int unsigned AddrWidth      = 56,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumReq-1:0]                   s_mem_req_i,
    output logic [NumReq-1:0]                   s_mem_gnt_o,
    input  logic [NumReq-1:0][AddrWidth-1:0]    s_mem_addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    s_mem_wdata_i,
    input  logic [NumReq-1:0]                   s_mem_we_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]  s_mem_be_i,
    output logic [NumReq-1:0]                   s_mem_valid_o,
    output logic [DataWidth-1:0]                s_mem_rdata_o,
    output logic [NumReq-1:0]                   s_mem_error_o,
    output logic                                m_mem_req_o,
    input  logic                                m_mem_gnt_i,
    output logic [AddrWidth-1:0]                m_mem_addr_o,
    output logic [DataWidth-1:0]                m_mem_wdata_o,
    output logic                                m_mem_we_o,
    output logic [DataWidth/8-1:0]              m_mem_be_o,
    input  logic                                m_mem_valid_i,
    input  logic [DataWidth-1:0]                m_mem_rdata_i,
    input  logic                                m_mem_error_i,
    output logic                                spurious_rsp_o
);
    localparam int unsigned IW = NumReq > 1 ? $clog2(NumReq) : 1;
    localparam int unsigned PW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CW = $clog2(MaxOutstanding + 1);

    typedef enum logic {IDLE, WAIT_GNT} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] sel_q, sel_d, win_idx, idx;
    logic          active, grant, full, empty, pop;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] wr_q, rd_q;
    logic [IW-1:0] id_q [MaxOutstanding];
    logic          spurious_q;

`ifdef MPTW_ARB_RR_EN
    logic [IW-1:0] rr_q;
    // Scan from the farthest offset down so the closest requester to rr_q wins.
    always_comb begin
        win_idx = '0;
        for (int k = NumReq - 1; k >= 0; k--)
            if (s_mem_req_i[(int'(rr_q) + k) % NumReq]) win_idx = IW'((int'(rr_q) + k) % NumReq);
    end
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) rr_q <= '0;
        else if (grant) rr_q <= (32'(idx) == NumReq - 1) ? '0 : idx + 1'b1;
`else
    always_comb begin
        win_idx = '0;
        for (int k = NumReq - 1; k >= 0; k--)
            if (s_mem_req_i[k]) win_idx = IW'(k);
    end
`endif

    always_comb begin
        full          = cnt_q == CW'(MaxOutstanding);
        empty         = cnt_q == '0;
        idx           = state_q == WAIT_GNT ? sel_q : win_idx;
        active        = (state_q == WAIT_GNT ? s_mem_req_i[sel_q] : |s_mem_req_i) && !full;
        grant         = active && m_mem_gnt_i;
        pop           = m_mem_valid_i && !empty;
        state_d       = state_q;
        sel_d         = sel_q;
        if (state_q == IDLE && active && !m_mem_gnt_i) begin
            state_d = WAIT_GNT;
            sel_d   = win_idx;
        end
        if (state_q == WAIT_GNT && (grant || !s_mem_req_i[sel_q])) state_d = IDLE;
        m_mem_req_o   = active;
        m_mem_addr_o  = active ? s_mem_addr_i[idx] : '0;
        m_mem_wdata_o = active ? s_mem_wdata_i[idx] : '0;
        m_mem_we_o    = active && s_mem_we_i[idx];
        m_mem_be_o    = active ? s_mem_be_i[idx] : '0;
        s_mem_gnt_o   = '0;
        s_mem_gnt_o[idx] = grant;
        s_mem_valid_o = '0;
        s_mem_error_o = '0;
        s_mem_valid_o[id_q[rd_q]] = pop;
        s_mem_error_o[id_q[rd_q]] = pop && m_mem_error_i;
        s_mem_rdata_o = m_mem_rdata_i;
    end

    assign spurious_rsp_o = spurious_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            spurious_q <= 1'b0;
            for (int i = 0; i < MaxOutstanding; i++) id_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            if (grant) begin
                id_q[wr_q] <= idx;
                wr_q       <= wr_q == PW'(MaxOutstanding - 1) ? '0 : wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q == PW'(MaxOutstanding - 1) ? '0 : rd_q + 1'b1;
            cnt_q      <= cnt_q + CW'(grant) - CW'(pop);
            spurious_q <= spurious_q | (m_mem_valid_i && empty);
        end
    end
endmodule
